// File: rtl/cpu_control_unit.sv
`timescale 1ns/1ps
// Multi-cycle control/execute unit for the 16-bit four-register CPU.
// Sequences each accepted instruction through READ, EXEC and WB against a synchronous-read register file.
module cpu_control_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [1:0]  rf_r_addr1,
    output logic [1:0]  rf_r_addr2,
    input  logic [15:0] rf_r_data1,
    input  logic [15:0] rf_r_data2,
    output logic        rf_we,
    output logic [1:0]  rf_w_addr,
    output logic [15:0] rf_w_data,
    output logic        flag_z,
    output logic        flag_c,
    output logic        done,
    output logic        illegal
);
    localparam int unsigned DATA_W = 16;
    localparam int unsigned OP_W   = 4;

    localparam logic [OP_W-1:0] OP_ADD = 4'd1;
    localparam logic [OP_W-1:0] OP_SUB = 4'd2;
    localparam logic [OP_W-1:0] OP_AND = 4'd3;
    localparam logic [OP_W-1:0] OP_OR  = 4'd4;
    localparam logic [OP_W-1:0] OP_XOR = 4'd5;
    localparam logic [OP_W-1:0] OP_SHL = 4'd6;
    localparam logic [OP_W-1:0] OP_SHR = 4'd7;
    localparam logic [OP_W-1:0] OP_LDI = 4'd8;
    localparam logic [OP_W-1:0] OP_MOV = 4'd9;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

    state_t              state;
    state_t              next_state;
    logic [DATA_W-1:0]   instr_q;
    logic [DATA_W-1:0]   result_q;
    logic [OP_W-1:0]     op;
    logic                accept;
    logic                writes_rd;
    logic                is_illegal;
    logic [DATA_W:0]     sum;
    logic [DATA_W-1:0]   alu_res;
    logic                alu_c;
    logic                ready_d;
    logic                we_d;
    logic                done_d;
    logic                illegal_d;

    assign op         = instr_q[15:12];
    assign accept     = instr_valid && instr_ready;
    assign writes_rd  = (op != 4'd0) && (op <= OP_MOV);
    assign is_illegal = (op > OP_MOV);

    // Register-file ports come straight from registered instruction/result state
    assign rf_r_addr1 = instr_q[9:8];
    assign rf_r_addr2 = instr_q[7:6];
    assign rf_w_addr  = instr_q[11:10];
    assign rf_w_data  = result_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (accept) next_state = S_READ;
            S_READ:  next_state = S_EXEC;
            S_EXEC:  next_state = S_WB;
            S_WB:    next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Pulses are decoded from the upcoming state so they register cleanly into the cycle they belong to
    always_comb begin
        ready_d   = 1'b0;
        we_d      = 1'b0;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        case (next_state)
            S_IDLE: ready_d = 1'b1;
            S_WB: begin
                done_d    = 1'b1;
                we_d      = writes_rd;
                illegal_d = is_illegal;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_ready <= 1'b1;
            rf_we       <= 1'b0;
            done        <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            instr_ready <= ready_d;
            rf_we       <= we_d;
            done        <= done_d;
            illegal     <= illegal_d;
        end
    end

    assign sum = (DATA_W+1)'(rf_r_data1) + (DATA_W+1)'(rf_r_data2);

    // ALU; defaults hold result and carry for opcodes that leave them untouched
    always_comb begin
        alu_res = result_q;
        alu_c   = flag_c;
        case (op)
            OP_ADD: begin alu_res = sum[DATA_W-1:0];           alu_c = sum[DATA_W]; end
            OP_SUB: begin alu_res = rf_r_data1 - rf_r_data2;   alu_c = (rf_r_data1 < rf_r_data2); end
            OP_AND: begin alu_res = rf_r_data1 & rf_r_data2;   alu_c = 1'b0; end
            OP_OR:  begin alu_res = rf_r_data1 | rf_r_data2;   alu_c = 1'b0; end
            OP_XOR: begin alu_res = rf_r_data1 ^ rf_r_data2;   alu_c = 1'b0; end
            OP_SHL: begin alu_res = {rf_r_data1[14:0], 1'b0};  alu_c = rf_r_data1[15]; end
            OP_SHR: begin alu_res = {1'b0, rf_r_data1[15:1]};  alu_c = rf_r_data1[0]; end
            OP_LDI: alu_res = {8'h00, instr_q[7:0]};
            OP_MOV: alu_res = rf_r_data1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q  <= '0;
            result_q <= '0;
            flag_z   <= 1'b0;
            flag_c   <= 1'b0;
        end else begin
            if (accept) instr_q <= instr;
            if (state == S_EXEC && writes_rd) begin
                result_q <= alu_res;
                flag_z   <= (alu_res == '0);
                flag_c   <= alu_c;
            end
        end
    end
endmodule

// File: tb/tb_cpu_control_unit.sv
`timescale 1ns/1ps
// Directed bench for cpu_control_unit with a behavioural synchronous-read register file.
module tb_cpu_control_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [1:0]  rf_r_addr1, rf_r_addr2;
    logic [15:0] rf_r_data1, rf_r_data2;
    logic        rf_we;
    logic [1:0]  rf_w_addr;
    logic [15:0] rf_w_data;
    logic        flag_z, flag_c, done, illegal;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0]  obs_we, obs_done, obs_ill, obs_rdy;
    logic [1:0]  obs_a1, obs_a2, obs_waddr;
    logic [15:0] obs_wdata;
    logic        obs_z, obs_c;

    logic [15:0] regs [4];

    cpu_control_unit dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .rf_r_addr1(rf_r_addr1), .rf_r_addr2(rf_r_addr2), .rf_r_data1(rf_r_data1), .rf_r_data2(rf_r_data2),
        .rf_we(rf_we), .rf_w_addr(rf_w_addr), .rf_w_data(rf_w_data),
        .flag_z(flag_z), .flag_c(flag_c), .done(done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rf_r_data1 <= regs[rf_r_addr1];
        rf_r_data2 <= regs[rf_r_addr2];
        if (rf_we) regs[rf_w_addr] <= rf_w_data;
    end

    // Hand one instruction over and record READ/EXEC/WB cycles; returns at the WB sample point
    task automatic issue(input logic [15:0] ins, input bit keep);
        int n;
        @(negedge clk);
        instr = ins;
        instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: instr_ready=%b required 1", instr_ready);
        end
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            obs_we[i]   = rf_we;
            obs_done[i] = done;
            obs_ill[i]  = illegal;
            obs_rdy[i]  = instr_ready;
            if (i == 0) begin
                obs_a1 = rf_r_addr1;
                obs_a2 = rf_r_addr2;
                instr  = 16'hA5A5;
                if (!keep) instr_valid = 1'b0;
            end
        end
        obs_waddr = rf_w_addr;
        obs_wdata = rf_w_data;
        obs_z     = flag_z;
        obs_c     = flag_c;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        instr = 16'h0000;
        instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b expected 1", instr_ready); end
        n_checks++; if ({rf_we, done, illegal} !== 3'b000) begin n_fail++; $display("FAIL rst_pulses: got %b expected 000", {rf_we, done, illegal}); end
        n_checks++; if ({rf_r_addr1, rf_r_addr2, rf_w_addr} !== 6'd0) begin n_fail++; $display("FAIL rst_addrs: got %h expected 0", {rf_r_addr1, rf_r_addr2, rf_w_addr}); end
        n_checks++; if (rf_w_data !== 16'h0000) begin n_fail++; $display("FAIL rst_wdata: got %h expected 0000", rf_w_data); end
        n_checks++; if ({flag_z, flag_c} !== 2'b00) begin n_fail++; $display("FAIL rst_flags: got %b expected 00", {flag_z, flag_c}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ldi_timing();
        issue(16'h8434, 1'b0);
        n_checks++; if (obs_we !== 3'b100) begin n_fail++; $display("FAIL ldi_we: got %b expected 100", obs_we); end
        n_checks++; if (obs_done !== 3'b100) begin n_fail++; $display("FAIL ldi_done: got %b expected 100", obs_done); end
        n_checks++; if (obs_rdy !== 3'b000) begin n_fail++; $display("FAIL ldi_ready: got %b expected 000", obs_rdy); end
        n_checks++; if (obs_ill !== 3'b000) begin n_fail++; $display("FAIL ldi_illegal: got %b expected 000", obs_ill); end
        n_checks++; if (obs_waddr !== 2'd1 || obs_wdata !== 16'h0034) begin n_fail++; $display("FAIL ldi_write: got r%0d=%h expected r1=0034", obs_waddr, obs_wdata); end
        n_checks++; if (obs_z !== 1'b0) begin n_fail++; $display("FAIL ldi_z: got %b expected 0", obs_z); end
        @(negedge clk);
        n_checks++; if ({instr_ready, rf_we, done} !== 3'b100) begin n_fail++; $display("FAIL ldi_after_wb: got rdy/we/done %b expected 100", {instr_ready, rf_we, done}); end
    endtask

    task automatic test_dependent();
        issue(16'h80FF, 1'b0);
        issue(16'h8401, 1'b0);
        issue(16'h1840, 1'b0);
        n_checks++; if (obs_a1 !== 2'd0 || obs_a2 !== 2'd1) begin n_fail++; $display("FAIL add_raddr: got %0d,%0d expected 0,1", obs_a1, obs_a2); end
        n_checks++; if (obs_waddr !== 2'd2 || obs_wdata !== 16'h0100) begin n_fail++; $display("FAIL add_result: got r%0d=%h expected r2=0100", obs_waddr, obs_wdata); end
        n_checks++; if ({obs_z, obs_c} !== 2'b00) begin n_fail++; $display("FAIL add_flags: got zc=%b expected 00", {obs_z, obs_c}); end
        issue(16'h8C00, 1'b0);
        issue(16'h2340, 1'b0);
        n_checks++; if (obs_wdata !== 16'hFFFF || {obs_z, obs_c} !== 2'b01) begin n_fail++; $display("FAIL sub_ffff: got %h zc=%b expected ffff zc=01", obs_wdata, {obs_z, obs_c}); end
        issue(16'h1C40, 1'b0);
        n_checks++; if (obs_waddr !== 2'd3 || obs_wdata !== 16'h0000) begin n_fail++; $display("FAIL add_wrap: got r%0d=%h expected r3=0000", obs_waddr, obs_wdata); end
        n_checks++; if ({obs_z, obs_c} !== 2'b11) begin n_fail++; $display("FAIL add_wrap_flags: got zc=%b expected 11", {obs_z, obs_c}); end
        n_checks++; if (obs_we !== 3'b100) begin n_fail++; $display("FAIL add_wrap_we: got %b expected 100", obs_we); end
    endtask

    task automatic test_sub_logic();
        issue(16'h8003, 1'b0);
        issue(16'h8405, 1'b0);
        issue(16'h2840, 1'b0);
        n_checks++; if (obs_wdata !== 16'hFFFE || {obs_z, obs_c} !== 2'b01) begin n_fail++; $display("FAIL sub_borrow: got %h zc=%b expected fffe zc=01", obs_wdata, {obs_z, obs_c}); end
        issue(16'h9C00, 1'b0);
        n_checks++; if (obs_wdata !== 16'h0003 || {obs_z, obs_c} !== 2'b01) begin n_fail++; $display("FAIL mov_hold_c: got %h zc=%b expected 0003 zc=01", obs_wdata, {obs_z, obs_c}); end
        issue(16'h3840, 1'b0);
        n_checks++; if (obs_wdata !== 16'h0001 || {obs_z, obs_c} !== 2'b00) begin n_fail++; $display("FAIL and: got %h zc=%b expected 0001 zc=00", obs_wdata, {obs_z, obs_c}); end
        issue(16'h4840, 1'b0);
        n_checks++; if (obs_wdata !== 16'h0007) begin n_fail++; $display("FAIL or: got %h expected 0007", obs_wdata); end
        issue(16'h5840, 1'b0);
        n_checks++; if (obs_wdata !== 16'h0006) begin n_fail++; $display("FAIL xor: got %h expected 0006", obs_wdata); end
        issue(16'h2D40, 1'b0);
        n_checks++; if (obs_wdata !== 16'h0000 || {obs_z, obs_c} !== 2'b10) begin n_fail++; $display("FAIL sub_equal: got %h zc=%b expected 0000 zc=10", obs_wdata, {obs_z, obs_c}); end
    endtask

    task automatic test_shift();
        issue(16'h8080, 1'b0);
        for (int i = 0; i < 8; i++) issue(16'h6000, 1'b0);
        n_checks++; if (obs_wdata !== 16'h8000 || obs_c !== 1'b0) begin n_fail++; $display("FAIL shl_chain: got %h c=%b expected 8000 c=0", obs_wdata, obs_c); end
        issue(16'h8401, 1'b0);
        issue(16'h4040, 1'b0);
        issue(16'h6800, 1'b0);
        n_checks++; if (obs_wdata !== 16'h0002 || {obs_z, obs_c} !== 2'b01) begin n_fail++; $display("FAIL shl: got %h zc=%b expected 0002 zc=01", obs_wdata, {obs_z, obs_c}); end
        issue(16'h8C03, 1'b0);
        issue(16'h7B00, 1'b0);
        n_checks++; if (obs_a1 !== 2'd3 || obs_a2 !== 2'd0) begin n_fail++; $display("FAIL shr_raddr: got %0d,%0d expected 3,0", obs_a1, obs_a2); end
        n_checks++; if (obs_waddr !== 2'd2 || obs_wdata !== 16'h0001 || {obs_z, obs_c} !== 2'b01) begin n_fail++; $display("FAIL shr: got r%0d=%h zc=%b expected r2=0001 zc=01", obs_waddr, obs_wdata, {obs_z, obs_c}); end
    endtask

    task automatic test_reset_abort();
        logic saw;
        @(negedge clk);
        instr = 16'h1C40;
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b expected 1", instr_ready); end
        n_checks++; if ({flag_z, flag_c} !== 2'b00) begin n_fail++; $display("FAIL abort_flags: got zc=%b expected 00", {flag_z, flag_c}); end
        saw = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rf_we !== 1'b0 || done !== 1'b0) saw = 1'b1;
        end
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (rf_we !== 1'b0 || done !== 1'b0) saw = 1'b1;
        end
        n_checks++; if (saw !== 1'b0) begin n_fail++; $display("FAIL abort_no_write: got pulse=%b expected 0", saw); end
        issue(16'h885A, 1'b0);
        n_checks++; if (obs_we !== 3'b100 || obs_done !== 3'b100) begin n_fail++; $display("FAIL post_reset_pulses: got we=%b done=%b expected 100/100", obs_we, obs_done); end
        n_checks++; if (obs_waddr !== 2'd2 || obs_wdata !== 16'h005A) begin n_fail++; $display("FAIL post_reset_write: got r%0d=%h expected r2=005a", obs_waddr, obs_wdata); end
    endtask

    task automatic test_illegal_nop();
        issue(16'h1C00, 1'b0);
        n_checks++; if (obs_wdata !== 16'h0002 || {obs_z, obs_c} !== 2'b01) begin n_fail++; $display("FAIL add_self: got %h zc=%b expected 0002 zc=01", obs_wdata, {obs_z, obs_c}); end
        issue(16'hF000, 1'b1);
        n_checks++; if (obs_ill !== 3'b100 || obs_done !== 3'b100) begin n_fail++; $display("FAIL illegal_pulses: got ill=%b done=%b expected 100/100", obs_ill, obs_done); end
        n_checks++; if (obs_we !== 3'b000 || obs_rdy !== 3'b000) begin n_fail++; $display("FAIL illegal_we_ready: got we=%b rdy=%b expected 000/000", obs_we, obs_rdy); end
        n_checks++; if ({obs_z, obs_c} !== 2'b01) begin n_fail++; $display("FAIL illegal_flags: got zc=%b expected 01", {obs_z, obs_c}); end
        issue(16'h0000, 1'b1);
        n_checks++; if (obs_ill !== 3'b000 || obs_done !== 3'b100) begin n_fail++; $display("FAIL nop_pulses: got ill=%b done=%b expected 000/100", obs_ill, obs_done); end
        n_checks++; if (obs_we !== 3'b000 || obs_rdy !== 3'b000) begin n_fail++; $display("FAIL nop_we_ready: got we=%b rdy=%b expected 000/000", obs_we, obs_rdy); end
        n_checks++; if ({obs_z, obs_c} !== 2'b01) begin n_fail++; $display("FAIL nop_flags: got zc=%b expected 01", {obs_z, obs_c}); end
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            instr = 16'h8434 ^ 16'(i);
            n_checks++; if ({instr_ready, rf_we, done, illegal} !== 4'b1000) begin n_fail++; $display("FAIL idle_hold: cycle %0d got rdy/we/done/ill %b expected 1000", i, {instr_ready, rf_we, done, illegal}); end
        end
    endtask

    initial begin
        test_reset();
        test_ldi_timing();
        test_dependent();
        test_sub_logic();
        test_shift();
        test_reset_abort();
        test_illegal_nop();
        test_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
